// File: rtl/zimbo_run_monitor.sv
// Run monitor for a small core: counts run cycles and memory writes between
// start and a halt opcode, with an optional cycle-limit watchdog.
module zimbo_run_monitor #(
    parameter int unsigned         OPW        = 5,
    parameter logic [OPW-1:0]      HALT_OP    = {OPW{1'b1}},
    parameter int unsigned         CNTW       = 32,
    parameter int unsigned         TIMEOUT    = 0,
    parameter bit                  AUTO_START = 1'b1
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [OPW-1:0]  opcode,
    input  logic            memwr_en,
    input  logic            start,
    input  logic            clear,
    output logic [CNTW-1:0] cycle_count,
    output logic [CNTW-1:0] wr_count,
    output logic            busy,
    output logic            halted,
    output logic            timed_out,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        HALTED   = 2'd2,
        TIMEDOUT = 2'd3
    } state_e;

    // One extra bit so the limit compare cannot wrap at the top of the range.
    localparam logic [CNTW:0]   TIMEOUT_EXT = (CNTW+1)'(TIMEOUT);
    localparam logic [CNTW-1:0] CNT_MAX     = {CNTW{1'b1}};

    state_e          state_q, state_d;
    logic [CNTW-1:0] cyc_q, cyc_d;
    logic [CNTW-1:0] wr_q, wr_d;
    logic            done_q, done_d;

    logic isHalt;
    logic hitLimit;

    assign isHalt   = (opcode == HALT_OP);
    assign hitLimit = (TIMEOUT != 0) && (({1'b0, cyc_q} + 1'b1) == TIMEOUT_EXT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            wr_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
        end
    end

    // clear overrides everything; halt beats the timeout on the same edge.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        wr_d    = wr_q;
        done_d  = 1'b0;

        if (clear) begin
            state_d = IDLE;
            cyc_d   = '0;
            wr_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (AUTO_START || start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (memwr_en && (wr_q != CNT_MAX)) begin
                        wr_d = wr_q + 1'b1;
                    end
                    if (isHalt) begin
                        state_d = HALTED;
                        done_d  = 1'b1;
                    end else if (hitLimit) begin
                        state_d = TIMEDOUT;
                        cyc_d   = TIMEOUT_EXT[CNTW-1:0];
                        done_d  = 1'b1;
                    end else if (cyc_q != CNT_MAX) begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
                HALTED:   state_d = HALTED;
                TIMEDOUT: state_d = TIMEDOUT;
                default:  state_d = IDLE;
            endcase
        end
    end

    assign cycle_count = cyc_q;
    assign wr_count    = wr_q;
    assign busy        = (state_q == RUN);
    assign halted      = (state_q == HALTED);
    assign timed_out   = (state_q == TIMEDOUT);
    assign done        = done_q;

endmodule

// File: tb/tb_zimbo_run_monitor.sv
// Directed bench for zimbo_run_monitor: four instances cover the default,
// timeout, narrow-counter and manual-start configurations.
module tb_zimbo_run_monitor;

    logic       clock;
    logic       resetN;
    logic [4:0] opc   [4];
    logic       memWr [4];
    logic       startReq [4];
    logic       clearReq [4];

    logic [31:0] cyc0, wr0, cyc1, wr1, cyc3, wr3;
    logic [3:0]  cyc2, wr2;
    logic        busy   [4];
    logic        halted [4];
    logic        tmo    [4];
    logic        done   [4];

    int errCount;
    int checkCount;

    zimbo_run_monitor u0 (
        .clock(clock), .reset_n(resetN), .opcode(opc[0]), .memwr_en(memWr[0]),
        .start(startReq[0]), .clear(clearReq[0]), .cycle_count(cyc0), .wr_count(wr0),
        .busy(busy[0]), .halted(halted[0]), .timed_out(tmo[0]), .done(done[0])
    );

    zimbo_run_monitor #(.TIMEOUT(10)) u1 (
        .clock(clock), .reset_n(resetN), .opcode(opc[1]), .memwr_en(memWr[1]),
        .start(startReq[1]), .clear(clearReq[1]), .cycle_count(cyc1), .wr_count(wr1),
        .busy(busy[1]), .halted(halted[1]), .timed_out(tmo[1]), .done(done[1])
    );

    zimbo_run_monitor #(.CNTW(4)) u2 (
        .clock(clock), .reset_n(resetN), .opcode(opc[2]), .memwr_en(memWr[2]),
        .start(startReq[2]), .clear(clearReq[2]), .cycle_count(cyc2), .wr_count(wr2),
        .busy(busy[2]), .halted(halted[2]), .timed_out(tmo[2]), .done(done[2])
    );

    zimbo_run_monitor #(.AUTO_START(1'b0)) u3 (
        .clock(clock), .reset_n(resetN), .opcode(opc[3]), .memwr_en(memWr[3]),
        .start(startReq[3]), .clear(clearReq[3]), .cycle_count(cyc3), .wr_count(wr3),
        .busy(busy[3]), .halted(halted[3]), .timed_out(tmo[3]), .done(done[3])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        errCount   = 0;
        checkCount = 0;
        resetN     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            opc[i]      = 5'd0;
            memWr[i]    = 1'b0;
            startReq[i] = 1'b0;
            clearReq[i] = 1'b0;
        end
        #1;
        checkOutput("reset_cyc",  cyc0,                  32'd0);
        checkOutput("reset_wr",   wr0,                   32'd0);
        checkOutput("reset_flags",
                    {28'd0, busy[0], halted[0], tmo[0], done[0]}, 32'd0);

        tick(2);
        resetN = 1'b1;
        tick(1);
        checkOutput("auto_start_busy", 32'(busy[0]), 32'd1);
        checkOutput("auto_start_cyc0", cyc0,         32'd0);
        checkOutput("manual_idle",     32'(busy[3]), 32'd0);

        // Default config: 40 counted edges, 6 writes before the halt edge.
        for (int i = 0; i < 40; i++) begin
            memWr[0] = (i < 6);
            tick(1);
        end
        checkOutput("run40_cyc",  cyc0,         32'd40);
        checkOutput("run40_wr",   wr0,          32'd6);
        checkOutput("run40_busy", 32'(busy[0]), 32'd1);
        opc[0]   = 5'd31;
        memWr[0] = 1'b1;
        tick(1);
        checkOutput("halt_cyc",    cyc0,           32'd40);
        checkOutput("halt_wr",     wr0,            32'd7);
        checkOutput("halt_flag",   32'(halted[0]), 32'd1);
        checkOutput("halt_done",   32'(done[0]),   32'd1);
        checkOutput("halt_busy",   32'(busy[0]),   32'd0);
        opc[0]      = 5'd3;
        startReq[0] = 1'b1;
        tick(3);
        checkOutput("sticky_done", 32'(done[0]),   32'd0);
        checkOutput("sticky_halt", 32'(halted[0]), 32'd1);
        checkOutput("sticky_cyc",  cyc0,           32'd40);
        checkOutput("sticky_wr",   wr0,            32'd7);
        startReq[0] = 1'b0;

        // Timeout config: limit of 10 run edges.
        clearReq[1] = 1'b1;
        tick(1);
        checkOutput("to_clear_cyc", cyc1,        32'd0);
        checkOutput("to_clear_tmo", 32'(tmo[1]), 32'd0);
        clearReq[1] = 1'b0;
        tick(1);
        checkOutput("to_run_busy", 32'(busy[1]), 32'd1);
        tick(9);
        checkOutput("to_cyc9",  cyc1,         32'd9);
        checkOutput("to_busy9", 32'(busy[1]), 32'd1);
        tick(1);
        checkOutput("to_cyc10", cyc1,         32'd10);
        checkOutput("to_flag",  32'(tmo[1]),  32'd1);
        checkOutput("to_done",  32'(done[1]), 32'd1);
        checkOutput("to_busy",  32'(busy[1]), 32'd0);
        tick(1);
        checkOutput("to_done_low", 32'(done[1]), 32'd0);
        checkOutput("to_frozen",   cyc1,         32'd10);

        // Halt on the 10th edge must win over the timeout.
        clearReq[1] = 1'b1;
        tick(1);
        clearReq[1] = 1'b0;
        tick(1);
        tick(9);
        opc[1] = 5'd31;
        tick(1);
        checkOutput("prio_halt", 32'(halted[1]), 32'd1);
        checkOutput("prio_cyc",  cyc1,           32'd9);
        checkOutput("prio_tmo",  32'(tmo[1]),    32'd0);
        checkOutput("prio_done", 32'(done[1]),   32'd1);
        opc[1] = 5'd0;

        // Narrow counters saturate at 15.
        clearReq[2] = 1'b1;
        tick(1);
        checkOutput("sat_clear_cyc", 32'(cyc2), 32'd0);
        clearReq[2] = 1'b0;
        memWr[2]    = 1'b1;
        tick(1);
        tick(20);
        checkOutput("sat_cyc",  32'(cyc2),    32'd15);
        checkOutput("sat_wr",   32'(wr2),     32'd15);
        checkOutput("sat_busy", 32'(busy[2]), 32'd1);
        clearReq[2] = 1'b1;
        tick(1);
        checkOutput("sat_clr_busy", 32'(busy[2]), 32'd0);
        checkOutput("sat_clr_cyc",  32'(cyc2),    32'd0);
        checkOutput("sat_clr_wr",   32'(wr2),     32'd0);
        clearReq[2] = 1'b0;
        memWr[2]    = 1'b0;
        tick(1);
        checkOutput("sat_rerun", 32'(busy[2]), 32'd1);

        // Manual start: clear beats start, then start alone runs.
        startReq[3] = 1'b1;
        clearReq[3] = 1'b1;
        tick(1);
        checkOutput("man_clr_prio", 32'(busy[3]), 32'd0);
        clearReq[3] = 1'b0;
        tick(1);
        checkOutput("man_start", 32'(busy[3]), 32'd1);
        startReq[3] = 1'b0;
        memWr[3]    = 1'b1;
        tick(3);
        checkOutput("man_cyc3", cyc3, 32'd3);
        checkOutput("man_wr3",  wr3,  32'd3);

        // Reset in the middle of a run clears everything without a clock edge.
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 32'(busy[3]),   32'd0);
        checkOutput("rst_mid_cyc",  cyc3,           32'd0);
        checkOutput("rst_mid_wr",   wr3,            32'd0);
        checkOutput("rst_u0_halt",  32'(halted[0]), 32'd0);
        checkOutput("rst_u0_cyc",   cyc0,           32'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/zimbo_run_monitor.md
ZIMBO_RUN_MONITOR -- requirements
Module: zimbo_run_monitor

Interface
REQ-001 Parameter OPW, default 5, opcode width in bits.
REQ-002 Parameter HALT_OP, default 5'b11111, opcode value that terminates a run.
REQ-003 Parameter CNTW, default 32, width of both counters.
REQ-004 Parameter TIMEOUT, default 0, maximum run cycles; 0 disables the timeout.
REQ-005 Parameter AUTO_START, default 1; when 1, IDLE moves to RUN without `start`.
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 opcode  input  OPW  current core opcode, sampled each rising edge.
REQ-009 memwr_en  input  1  core memory write strobe, sampled each rising edge.
REQ-010 start  input  1  synchronous run request, honoured only in IDLE.
REQ-011 clear  input  1  synchronous return to IDLE with counters zeroed.
REQ-012 cycle_count  output  CNTW  run cycles counted.
REQ-013 wr_count  output  CNTW  memory writes counted during the run.
REQ-014 busy  output  1  high while the state is RUN.
REQ-015 halted  output  1  high while the state is HALTED.
REQ-016 timed_out  output  1  high while the state is TIMEDOUT.
REQ-017 done  output  1  one-cycle pulse on entry to HALTED or TIMEDOUT.

Function
REQ-018 The FSM SHALL have four states: IDLE, RUN, HALTED and TIMEDOUT.
REQ-019 IDLE SHALL go to RUN on the next edge when AUTO_START=1 or start=1; otherwise it stays in IDLE.
REQ-020 In RUN, an edge with opcode!=HALT_OP SHALL increment cycle_count by 1.
REQ-021 In RUN, an edge with opcode==HALT_OP SHALL go to HALTED with no increment; the final count equals the number of non-halt cycles.
REQ-022 In RUN, an edge with memwr_en=1 SHALL increment wr_count, including the halting edge.
REQ-023 With TIMEOUT!=0, a RUN edge where opcode!=HALT_OP and cycle_count+1==TIMEOUT SHALL load TIMEOUT into cycle_count and go to TIMEDOUT.
REQ-024 On the same edge, halt SHALL take priority over timeout.
REQ-025 Both counters SHALL saturate at all-ones and never wrap.
REQ-026 HALTED and TIMEDOUT SHALL be sticky: counters frozen, opcode, memwr_en and start ignored, until `clear` or reset.
REQ-027 done SHALL be registered and high for exactly the one cycle after the edge that enters HALTED or TIMEDOUT.
REQ-028 clear=1 SHALL, from any state, go to IDLE, zero both counters and deassert done on the next edge.
REQ-029 clear SHALL take priority over start and over every RUN transition on the same edge.
REQ-030 busy, halted and timed_out SHALL be decoded directly from the state register, with exactly one or none high.

Reset
REQ-031 With reset_n=0, the block SHALL enter IDLE asynchronously.
REQ-032 During reset, cycle_count, wr_count, busy, halted, timed_out and done SHALL all be 0.
REQ-033 Reset asserted mid-run SHALL discard the run immediately.
REQ-034 After reset_n rises, the first active edge SHALL follow REQ-019, so with AUTO_START=1 busy=1 one edge after release.

Verification
REQ-035 Defaults, release reset, drive opcode!=31 for 40 edges then opcode=31 -> cycle_count=40, halted=1, done high for 1 cycle.
REQ-036 memwr_en=1 on 7 run edges, one of them the halting edge -> wr_count=7 and stays frozen afterwards.
REQ-037 TIMEOUT=10, opcode never 31 -> cycle_count=10, timed_out=1, done pulse, busy=0.
REQ-038 TIMEOUT=10 with opcode=31 on the 10th run edge -> halted=1, cycle_count=9, timed_out=0.
REQ-039 CNTW=4, 20 run edges -> cycle_count=15, saturated; then clear -> IDLE, counts 0, and RUN again one edge later.
REQ-040 AUTO_START=0: start and clear together in IDLE -> stays IDLE; start alone -> busy=1; reset mid-run -> all outputs 0 immediately.
